// File: rtl/ma_window_ctrl.sv
// ma_window_ctrl: sequencing controller for the gyro moving-average filter.
// Keeps the running sum of the last 2^shift samples, walks a circular write
// pointer through an external single-port sample RAM and zeroes that RAM on
// every (re)start so warm-up outputs are simply (sum so far) >>> shift.
module ma_window_ctrl #(
  parameter int DATA_W        = 14,
  parameter int MAX_SHIFT     = 7,
  parameter int DEFAULT_SHIFT = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [3:0]               i_cfg_shift,
  input  logic                     i_cfg_load,
  input  logic signed [DATA_W-1:0] i_din,
  input  logic                     i_din_vld,
  output logic                     o_din_rdy,
  output logic [MAX_SHIFT-1:0]     o_ram_addr,
  output logic                     o_ram_we,
  output logic [DATA_W-1:0]        o_ram_wdata,
  input  logic signed [DATA_W-1:0] i_ram_rdata,
  output logic signed [DATA_W-1:0] o_dout,
  output logic                     o_dout_vld,
  output logic                     o_full,
  output logic                     o_busy
);
  localparam int SUM_W = DATA_W + MAX_SHIFT;
  localparam int CNT_W = MAX_SHIFT + 1;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RD    = 3'd2,
    ST_UPD   = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         clr_cnt_q, clr_cnt_d;
  logic [3:0]               shift_q, shift_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [MAX_SHIFT-1:0]     wptr_q, wptr_d;
  logic [CNT_W-1:0]         fill_q, fill_d;
  logic signed [DATA_W-1:0] sample_q, sample_d;
  logic [MAX_SHIFT-1:0]     ram_addr_q, ram_addr_d;
  logic                     ram_we_q, ram_we_d;
  logic [DATA_W-1:0]        ram_wdata_q, ram_wdata_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic                     dout_vld_q, dout_vld_d;
  logic                     full_q, full_d;

  logic [CNT_W-1:0]         win_len_s;
  logic [3:0]               cfg_shift_s;
  logic signed [SUM_W-1:0]  sum_upd_s;
  logic                     accept_s;

  // Window length N, clamped request and the updated sum (sample in, oldest out)
  assign win_len_s   = CNT_W'(1) << shift_q;
  assign cfg_shift_s = (i_cfg_shift > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : i_cfg_shift;
  assign sum_upd_s   = sum_q + {{MAX_SHIFT{sample_q[DATA_W-1]}}, sample_q}
                             - {{MAX_SHIFT{i_ram_rdata[DATA_W-1]}}, i_ram_rdata};

  // A pending config load always beats a new sample
  assign o_din_rdy = (state_q == ST_IDLE) & ~i_cfg_load;
  assign accept_s  = i_din_vld & o_din_rdy;
  assign o_busy    = (state_q != ST_IDLE);

  assign o_ram_addr  = ram_addr_q;
  assign o_ram_we    = ram_we_q;
  assign o_ram_wdata = ram_wdata_q;
  assign o_dout      = dout_q;
  assign o_dout_vld  = dout_vld_q;
  assign o_full      = full_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      shift_q     <= 4'(DEFAULT_SHIFT);
      sum_q       <= '0;
      wptr_q      <= '0;
      fill_q      <= '0;
      sample_q    <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      shift_q     <= shift_d;
      sum_q       <= sum_d;
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      sample_q    <= sample_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      full_q      <= full_d;
    end
  end

  // Next-state: clear sweep, then one accept/read/update/output round per sample
  always_comb begin
    state_d = state_q;
    if (i_cfg_load) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_CLEAR: state_d = (clr_cnt_q == win_len_s) ? ST_IDLE : ST_CLEAR;
        ST_IDLE:  state_d = accept_s ? ST_RD : ST_IDLE;
        ST_RD:    state_d = ST_UPD;
        ST_UPD:   state_d = ST_OUT;
        ST_OUT:   state_d = ST_IDLE;
        default:  state_d = ST_CLEAR;
      endcase
    end
  end

  // Datapath and registered RAM/output values for the coming cycle
  always_comb begin
    clr_cnt_d   = clr_cnt_q;
    shift_d     = shift_q;
    sum_d       = sum_q;
    wptr_d      = wptr_q;
    fill_d      = fill_q;
    sample_d    = sample_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    dout_d      = dout_q;
    dout_vld_d  = 1'b0;
    full_d      = full_q;
    if (i_cfg_load) begin
      // Restart: new window, empty sum, in-flight sample dropped, dout kept
      shift_d     = cfg_shift_s;
      clr_cnt_d   = '0;
      sum_d       = '0;
      wptr_d      = '0;
      fill_d      = '0;
      full_d      = 1'b0;
      ram_addr_d  = '0;
      ram_wdata_d = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          sum_d  = '0;
          wptr_d = '0;
          fill_d = '0;
          if (clr_cnt_q != win_len_s) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = clr_cnt_q[MAX_SHIFT-1:0];
            ram_wdata_d = '0;
            clr_cnt_d   = clr_cnt_q + CNT_W'(1);
          end else begin
            clr_cnt_d = clr_cnt_q;
          end
        end
        ST_IDLE: begin
          // Present the oldest sample's address for reading
          if (accept_s) begin
            sample_d   = i_din;
            ram_addr_d = wptr_q;
          end else begin
            sample_d = sample_q;
          end
        end
        ST_RD: begin
          // Read data arrives next cycle; overwrite the same slot then
          ram_we_d    = 1'b1;
          ram_addr_d  = wptr_q;
          ram_wdata_d = sample_q;
        end
        ST_UPD: begin
          sum_d      = sum_upd_s;
          dout_d     = DATA_W'(sum_upd_s >>> shift_q);
          dout_vld_d = 1'b1;
          if (fill_q != win_len_s) begin
            fill_d = fill_q + CNT_W'(1);
          end else begin
            fill_d = fill_q;
          end
          full_d = (fill_d == win_len_s);
        end
        ST_OUT: begin
          if ({1'b0, wptr_q} == (win_len_s - CNT_W'(1))) begin
            wptr_d = '0;
          end else begin
            wptr_d = wptr_q + MAX_SHIFT'(1);
          end
        end
        default: begin
          sum_d = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ma_window_ctrl.sv
// tb_ma_window_ctrl: directed + randomized bench for ma_window_ctrl with a
// behavioural RAM and a queue-based moving-average reference model.
module tb_ma_window_ctrl;
  localparam int DW = 14;
  localparam int MS = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           cfg_shift;
  logic                 cfg_load;
  logic signed [DW-1:0] din;
  logic                 din_vld;
  logic                 din_rdy;
  logic [MS-1:0]        ram_addr;
  logic                 ram_we;
  logic [DW-1:0]        ram_wdata;
  logic signed [DW-1:0] ram_rdata = '0;
  logic signed [DW-1:0] dout;
  logic                 dout_vld;
  logic                 full;
  logic                 busy;

  logic signed [DW-1:0] mem [0:127];

  int checks = 0;
  int errors = 0;
  int m_shift, m_n, m_k, last_dout;
  int hist[$];

  always #5 clk = ~clk;

  ma_window_ctrl #(.DATA_W(DW), .MAX_SHIFT(MS), .DEFAULT_SHIFT(7)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_shift(cfg_shift), .i_cfg_load(cfg_load),
    .i_din(din), .i_din_vld(din_vld), .o_din_rdy(din_rdy),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata), .o_dout(dout), .o_dout_vld(dout_vld),
    .o_full(full), .o_busy(busy)
  );

  // Single-port synchronous RAM, read-first; filled with junk during reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 14'sh1555;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: window is the last N accepted samples (zeros after restart)
  task automatic model_restart(input int req);
    m_shift = (req > MS) ? MS : req;
    m_n = 1 << m_shift;
    m_k = 0;
    hist.delete();
    for (int i = 0; i < m_n; i++) hist.push_back(0);
  endtask

  function automatic int model_avg();
    int s;
    s = 0;
    foreach (hist[i]) s += hist[i];
    return s >>> m_shift;
  endfunction

  // Starts in the first cycle after a reset release or load edge
  task automatic wait_clear(input string tag);
    int bad;
    bad = 0;
    check({tag, "_c0"}, {30'd0, busy, ram_we}, 2);
    for (int c = 1; c <= m_n; c++) begin
      tick;
      if (!(ram_we === 1'b1 && int'(ram_addr) == c - 1 && ram_wdata == '0 &&
            busy === 1'b1 && din_rdy === 1'b0 && dout_vld === 1'b0)) bad++;
    end
    check({tag, "_seq"}, bad, 0);
    tick;
    check({tag, "_idle"}, {30'd0, busy, din_rdy}, 1);
    check({tag, "_full"}, int'(full), 0);
    check({tag, "_dout_held"}, int'(dout), last_dout);
  endtask

  task automatic apply_cfg(input int req);
    cfg_shift = 4'(req);
    cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0;
    model_restart(req);
    wait_clear("clear");
  endtask

  task automatic send(input int s);
    int waitc, bad, vcnt, vlat, exp_addr, exp;
    waitc = 0;
    while (din_rdy !== 1'b1 && waitc < 300) begin
      tick;
      waitc++;
    end
    if (waitc >= 300) check("rdy_timeout", int'(din_rdy), 1);
    exp_addr = m_k % m_n;
    din = DW'(s);
    din_vld = 1'b1;
    tick;
    din_vld = 1'b0;
    hist.push_back(s);
    void'(hist.pop_front());
    m_k++;
    exp = model_avg();
    bad = 0; vcnt = 0; vlat = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        if (!(ram_we === 1'b1 && int'(ram_addr) == exp_addr && $signed(ram_wdata) == DW'(s))) bad++;
      end else if (ram_we !== 1'b0) bad++;
      if (din_rdy !== ((c >= 4) ? 1'b1 : 1'b0)) bad++;
      if (dout_vld === 1'b1) begin vcnt++; vlat = c; end
      if (c < 5) tick;
    end
    check("ram_rdy_seq", bad, 0);
    check("vld_count", vcnt, 1);
    check("vld_latency", vlat, 3);
    check("dout", int'(dout), exp);
    check("full", int'(full), (m_k >= m_n) ? 1 : 0);
    last_dout = int'(dout);
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_shift = 4'd0; din = '0; din_vld = 1'b0;
    last_dout = 0;
    tick; tick;
    check("rst_busy", int'(busy), 1);
    check("rst_rdy", int'(din_rdy), 0);
    check("rst_ram", {8'd0, ram_we, ram_addr, 16'd0} | int'(ram_wdata), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_vld_full", {30'd0, dout_vld, full}, 0);
    rst = 1'b0;
    model_restart(7);
    wait_clear("rst_clear");

    // Constant +100 over a 128 window: ramp then plateau
    for (int i = 1; i <= 130; i++) begin
      send(100);
      if (m_k == 1)   check("k1_dout", int'(dout), 0);
      if (m_k == 64)  check("k64_dout", int'(dout), 50);
      if (m_k == 127) check("k127_full", int'(full), 0);
      if (m_k == 128) check("k128_dout_full", int'(dout) * 2 + int'(full), 201);
      if (m_k == 130) check("k130_dout", int'(dout), 100);
    end

    // Small window: floor toward -inf and oldest-sample removal at wrap
    apply_cfg(2);
    send(-1); check("w4_1", int'(dout), -1);
    send(0);  check("w4_2", int'(dout), -1);
    send(0);  check("w4_3", int'(dout), -1);
    send(0);  check("w4_4", int'(dout), -1);
    send(0);  check("w4_5", int'(dout), 0);
    send(8);  check("w4_6", int'(dout), 2);

    // Out-of-range request clamps to the 128 window
    apply_cfg(12);
    check("clamp_shift", m_n, 128);
    send(-128); check("clamp_dout", int'(dout), -1);

    // Randomized windows and samples against the reference
    for (int r = 0; r < 4; r++) begin
      apply_cfg(int'($urandom_range(0, 9)));
      for (int j = 0; j < ((m_n <= 16) ? m_n + 3 : 20); j++)
        send(int'($urandom_range(0, 16383)) - 8192);
    end

    // Load while a sample is in flight (RD): no output, sum restarts
    apply_cfg(3);
    send(800); send(800);
    while (din_rdy !== 1'b1) tick;
    din = 14'sd500; din_vld = 1'b1;
    tick;
    din_vld = 1'b0;
    apply_cfg(3);
    send(16); check("abandon_restart", int'(dout), 2);

    // Load and sample together in IDLE: sample dropped
    din = 14'sd7000; din_vld = 1'b1; cfg_shift = 4'd2; cfg_load = 1'b1;
    #1;
    check("cfg_vs_din_rdy", int'(din_rdy), 0);
    tick;
    din_vld = 1'b0; cfg_load = 1'b0;
    model_restart(2);
    wait_clear("drop_clear");
    send(40); check("drop_first", int'(dout), 10);
    send(-40); check("drop_second", int'(dout), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ma_window_ctrl.md
Name: ma_window_ctrl

Overview:
- Sequencing controller for the gyro moving-average filter.
- Owns the running sum, the circular write pointer, warm-up tracking and the window-length configuration.
- Drives an external single-port sample RAM (synchronous read, 1-cycle latency) that holds the last 2^shift samples.
- Sits between the demodulated sample stream and the loop filter; the window length is reconfigured at run time without a reset.

Parameters:
- DATA_W, 14, signed sample width (din, dout, RAM word).
- MAX_SHIFT, 7, log2 of maximum window (128); also RAM address width.
- DEFAULT_SHIFT, 7, window exponent loaded at reset.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_cfg_shift  in  4  requested window exponent; values > MAX_SHIFT clamp to MAX_SHIFT.
- i_cfg_load  in  1  one-cycle pulse; latches i_cfg_shift and restarts the filter.
- i_din  in  DATA_W  signed input sample.
- i_din_vld  in  1  input sample valid.
- o_din_rdy  out  1  sample accepted when i_din_vld & o_din_rdy.
- o_ram_addr  out  MAX_SHIFT  RAM address (registered).
- o_ram_we  out  1  RAM write enable (registered).
- o_ram_wdata  out  DATA_W  RAM write data (registered).
- i_ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented with we=0.
- o_dout  out  DATA_W  signed averaged output.
- o_dout_vld  out  1  one-cycle strobe, o_dout updated.
- o_full  out  1  window filled since last restart.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - state=CLEAR, clr_cnt=0, shift=DEFAULT_SHIFT, sum=0, wptr=0, fill_cnt=0.
  - o_dout=0, o_dout_vld=0, o_full=0, o_busy=1.
  - o_ram_we=0, o_ram_addr=0, o_ram_wdata=0.
- Window: N = 2^shift.
- Running sum:
  - Signed, DATA_W+MAX_SHIFT bits; cannot overflow.
  - o_dout = sum >>> shift (arithmetic shift, floor toward -inf); always fits DATA_W, no saturation logic.
- States:
  - CLEAR:
    - o_ram_we=1, o_ram_wdata=0, o_ram_addr=clr_cnt; clr_cnt increments each cycle.
    - After writing address N-1 (N cycles total), go to IDLE.
    - sum, wptr and fill_cnt are held at 0.
  - IDLE:
    - o_din_rdy = (state==IDLE) & ~i_cfg_load (combinational).
    - On accept: latch i_din into sample register, present o_ram_addr=wptr with we=0, go to RD.
  - RD: wait one cycle for read data; go to UPD.
  - UPD:
    - old = i_ram_rdata; sum <= sum + sample - old.
    - Write sample at wptr (we=1).
    - Go to OUT.
  - OUT:
    - o_dout <= (updated sum) >>> shift; o_dout_vld=1 for this cycle.
    - wptr <= (wptr==N-1) ? 0 : wptr+1.
    - fill_cnt saturates at N; o_full=1 once fill_cnt==N.
    - Go to IDLE.
- Latency and throughput:
  - Accept in cycle T -> o_dout_vld in cycle T+3.
  - Throughput: one sample per 4 cycles.
- Warm-up: the RAM is zeroed in CLEAR, so outputs before the window fills equal (sum of samples so far) >>> shift.
- i_cfg_load, any state:
  - Next cycle: shift <= min(i_cfg_shift, MAX_SHIFT), state <= CLEAR, clr_cnt=0, sum=0, wptr=0, fill_cnt=0, o_full=0.
  - Any in-flight sample is abandoned; no o_dout_vld is produced for it.
  - o_dout holds its last value.
- i_cfg_load together with i_din_vld in IDLE: the config wins and the sample is not accepted (rdy=0).
- i_cfg_load during CLEAR: the clear restarts from address 0 with the new N.
- i_rst mid-operation: returns to reset values the next edge; the clear is re-run with DEFAULT_SHIFT.
- o_ram_we is never asserted in IDLE, RD or OUT.

Test Plan:
- Reset, then hold: 128 consecutive writes of 0 to addresses 0..127, o_busy=1 throughout, o_din_rdy=0; IDLE on cycle 129 after reset deassertion.
- Shift=7, constant din=+100: after k-th sample o_dout = floor(100k/128) (k=1 -> 0, k=64 -> 50); k=128 -> 100 and o_full=1; stays 100 for k>128; each vld exactly 3 cycles after accept.
- cfg_load shift=2 (4 clears), din sequence -1,0,0,0,0 -> outputs -1,-1,-1,-1,0 (floor check plus oldest-sample removal at wrap); wptr wraps 3->0.
- i_cfg_shift=12 -> clamped to 7; CLEAR lasts 128 cycles.
- Accept sample, assert cfg_load in RD -> no o_dout_vld; CLEAR starts next cycle; sum restarts at 0.
- cfg_load and din_vld asserted together in IDLE -> o_din_rdy=0, sample dropped; the first output after the new clear reflects only later samples.
